// File: rtl/struct_s.sv
// Shared packet-buffer types and constants.
//   PKTBUF_AWIDTH      : packet-buffer address width
//   flit_t             : one packet-buffer word (read data)
//   arb_state_t        : read-arbiter lock state
//   PKTBUF_ARB_MAX_OUT : default in-flight read limit of the read arbiter
package struct_s;

    localparam int PKTBUF_AWIDTH = 12;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } flit_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int PKTBUF_ARB_MAX_OUT = 8;

    // Tag width for n requesters; never zero so one requester still has a tag bit.
    function automatic int arb_tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pktbuf_read_arbiter_tag_fifo.sv
// Ordered tag FIFO for in-flight packet-buffer reads.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   push, push_data     : enqueue a requester tag
//   pop, pop_data       : dequeue; pop_data shows the head combinationally
//   empty, full         : occupancy flags
// Push and pop in the same cycle are allowed when non-empty, including when full.
module pktbuf_arb_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[PW-1:0]];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/pktbuf_read_arbiter.sv
// Packet-buffer read-port arbiter: round-robin between NUM_REQ requesters with a
// per-burst lock, credit-limited in-flight reads, and in-order response routing.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/addr/last/ready  : requester read channel (addr slice i*AWIDTH)
//   rsp_valid (one-hot), rsp_data : registered response to the issuing requester
//   pkt_buffer_address/read    : registered buffer read command
//   pkt_buffer_readvalid/data  : buffer returns, in issue order
//   err_spurious               : sticky, readvalid with nothing outstanding
// Optional build macro PKTBUF_ARB_STATS_EN adds stats_grant (per-requester
// accept counts, 32 bits each) and stats_stall (credit-blocked valid cycles).
//
// state      | meaning
// ARB_IDLE   | round-robin from rr_ptr+1 picks the next requester
// ARB_LOCKED | owner mid-burst; only owner may issue until req_last
module pktbuf_read_arbiter
    import struct_s::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int AWIDTH          = PKTBUF_AWIDTH,
    parameter int DWIDTH          = $bits(flit_t),
    parameter int MAX_OUTSTANDING = PKTBUF_ARB_MAX_OUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DWIDTH-1:0]         rsp_data,
    output logic [AWIDTH-1:0]         pkt_buffer_address,
    output logic                      pkt_buffer_read,
    input  logic                      pkt_buffer_readvalid,
    input  logic [DWIDTH-1:0]         pkt_buffer_readdata,
    output logic                      err_spurious
`ifdef PKTBUF_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]     stats_grant,
    output logic [31:0]               stats_stall
`endif
);
    localparam int TW = arb_tag_width(NUM_REQ);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_t          state_q, state_d;
    logic [TW-1:0]       owner_q, owner_d;
    logic [TW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       outstanding_q, outstanding_d;
    logic                rd_q, rd_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                err_q, err_d;

    logic                credit, accept, sel_last, pop, push;
    logic                win_found;
    logic [TW-1:0]       win_idx, acc_idx, head_tag;
    logic [AWIDTH-1:0]   sel_addr;
    logic                fifo_empty, fifo_full;

    assign credit = (outstanding_q < CW'(MAX_OUTSTANDING));

    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && req_valid[TW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = TW'(cand);
            end
        end
    end

    // The locked owner keeps ready even with req_valid low, so the lock holds.
    always_comb begin
        req_ready = '0;
        if (credit) begin
            if (state_q == ARB_IDLE) begin
                if (win_found) req_ready[win_idx] = 1'b1;
            end else begin
                req_ready[owner_q] = 1'b1;
            end
        end
    end

    assign acc_idx  = (state_q == ARB_IDLE) ? win_idx : owner_q;
    assign accept   = |(req_valid & req_ready);
    assign sel_addr = req_addr[int'(acc_idx)*AWIDTH +: AWIDTH];
    assign sel_last = req_last[acc_idx];
    assign pop      = pkt_buffer_readvalid && !fifo_empty;
    assign push     = accept && (!fifo_full || pop);

    pktbuf_arb_tag_fifo #(
        .WIDTH (TW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (acc_idx),
        .pop       (pop),
        .pop_data  (head_tag),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        outstanding_d = outstanding_q;
        rd_d          = accept;
        addr_d        = accept ? sel_addr : addr_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        err_d         = err_q | (pkt_buffer_readvalid && fifo_empty);
        if (accept) begin
            if (sel_last) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = acc_idx;
            end else begin
                state_d = ARB_LOCKED;
                owner_d = acc_idx;
            end
        end
        case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
        if (pop) begin
            rsp_valid_d[head_tag] = 1'b1;
            rsp_data_d            = pkt_buffer_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= TW'(NUM_REQ - 1);
            outstanding_q <= '0;
            rd_q          <= 1'b0;
            addr_q        <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            rd_q          <= rd_d;
            addr_q        <= addr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            err_q         <= err_d;
        end
    end

    assign pkt_buffer_read    = rd_q;
    assign pkt_buffer_address = addr_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_data           = rsp_data_q;
    assign err_spurious       = err_q;

`ifdef PKTBUF_ARB_STATS_EN
    logic [31:0] grant_cnt_q [NUM_REQ];
    logic [31:0] grant_cnt_d [NUM_REQ];
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (accept) grant_cnt_d[acc_idx] = grant_cnt_q[acc_idx] + 32'd1;
        stall_cnt_d = stall_cnt_q + ((|req_valid && !credit) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '{default: '0};
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        stats_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) stats_grant[i*32 +: 32] = grant_cnt_q[i];
    end
    assign stats_stall = stall_cnt_q;
`endif

endmodule
